// File: rtl/rv32_single_cycle_core.sv
// Single-cycle RV32I-subset core: addi, add, lw, sw, beq, bne.
// Fetch, decode, execute, memory and write-back all complete in one clock.
module rv32_single_cycle_core #(
    parameter int          IMEM_WORDS = 32,
    parameter int          DMEM_WORDS = 32,
    parameter logic [31:0] HALT_INSN  = 32'h00050f13
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        imem_we,
    input  logic [4:0]  imem_addr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] r_pc,
    output logic [31:0] w_ir,
    output logic [31:0] w_r1,
    output logic [31:0] w_s2,
    output logic [31:0] w_rt,
    output logic        halt
);

    logic [31:0] imem_r [IMEM_WORDS];
    logic [31:0] dmem_r [DMEM_WORDS];
    logic [31:0] regs_r [32];

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [4:0]  rd_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_s_s;
    logic [31:0] imm_b_s;
    logic [31:0] rs1_val_s;
    logic [31:0] rs2_val_s;
    logic [31:0] s2_s;
    logic [31:0] alu_s;
    logic [31:0] wb_data_s;
    logic [31:0] pc_next_s;
    logic        reg_we_s;
    logic        dmem_we_s;
    logic        load_s;
    logic        take_s;
    logic        halt_s;

    assign w_ir     = imem_r[r_pc[6:2]];
    assign opcode_s = w_ir[6:0];
    assign funct3_s = w_ir[14:12];
    assign funct7_s = w_ir[31:25];
    assign rs1_s    = w_ir[19:15];
    assign rs2_s    = w_ir[24:20];
    assign rd_s     = w_ir[11:7];
    assign imm_i_s  = {{20{w_ir[31]}}, w_ir[31:20]};
    assign imm_s_s  = {{20{w_ir[31]}}, w_ir[31:25], w_ir[11:7]};
    assign imm_b_s  = {{19{w_ir[31]}}, w_ir[31], w_ir[7], w_ir[30:25], w_ir[11:8], 1'b0};

    // x0 is hard-wired to zero regardless of array contents
    assign rs1_val_s = (rs1_s == 5'd0) ? 32'd0 : regs_r[rs1_s];
    assign rs2_val_s = (rs2_s == 5'd0) ? 32'd0 : regs_r[rs2_s];

    assign halt_s = (w_ir == HALT_INSN);
    assign alu_s  = rs1_val_s + s2_s;

    // Decode: operand select and write/branch enables; unknown encodings stay NOPs
    always_comb begin
        s2_s      = rs2_val_s;
        reg_we_s  = 1'b0;
        dmem_we_s = 1'b0;
        load_s    = 1'b0;
        take_s    = 1'b0;
        case (opcode_s)
            7'h13: begin
                s2_s = imm_i_s;
                if (funct3_s == 3'd0) reg_we_s = 1'b1;
                else                  reg_we_s = 1'b0;
            end
            7'h33: begin
                s2_s = rs2_val_s;
                if (funct3_s == 3'd0 && funct7_s == 7'd0) reg_we_s = 1'b1;
                else                                      reg_we_s = 1'b0;
            end
            7'h03: begin
                s2_s = imm_i_s;
                if (funct3_s == 3'd2) begin
                    reg_we_s = 1'b1;
                    load_s   = 1'b1;
                end else begin
                    reg_we_s = 1'b0;
                    load_s   = 1'b0;
                end
            end
            7'h23: begin
                s2_s = imm_s_s;
                if (funct3_s == 3'd2) dmem_we_s = 1'b1;
                else                  dmem_we_s = 1'b0;
            end
            7'h63: begin
                s2_s = rs2_val_s;
                if (funct3_s == 3'd0)      take_s = (rs1_val_s == rs2_val_s);
                else if (funct3_s == 3'd1) take_s = (rs1_val_s != rs2_val_s);
                else                       take_s = 1'b0;
            end
            default: begin
                s2_s = rs2_val_s;
            end
        endcase
    end

    // Write-back source and next PC; halt freezes the PC on the halt word
    always_comb begin
        if (load_s) wb_data_s = dmem_r[alu_s[6:2]];
        else        wb_data_s = alu_s;
        if (halt_s)      pc_next_s = r_pc;
        else if (take_s) pc_next_s = r_pc + imm_b_s;
        else             pc_next_s = r_pc + 32'd4;
    end

    // Program counter
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) r_pc <= 32'd0;
        else       r_pc <= pc_next_s;
    end

    // Register file write port; writes to x0 are dropped
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            for (int i = 0; i < 32; i++) regs_r[i] <= 32'd0;
        end else if (reg_we_s && rd_s != 5'd0) begin
            regs_r[rd_s] <= wb_data_s;
        end
    end

    // Instruction memory load port, independent of reset
    always_ff @(posedge w_clk) begin
        if (imem_we) imem_r[imem_addr] <= imem_wdata;
    end

    // Data memory store port
    always_ff @(posedge w_clk) begin
        if (dmem_we_s) dmem_r[alu_s[6:2]] <= rs2_val_s;
    end

    assign w_r1 = rs1_val_s;
    assign w_s2 = s2_s;
    assign w_rt = alu_s;
    assign halt = halt_s;

endmodule

// File: tb/tb_rv32_single_cycle_core.sv
// Directed bench for rv32_single_cycle_core: loop program, store/load, x0 and async reset.
module tb_rv32_single_cycle_core;

    logic        w_clk = 1'b0;
    logic        w_rst;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [31:0] r_pc;
    logic [31:0] w_ir;
    logic [31:0] w_r1;
    logic [31:0] w_s2;
    logic [31:0] w_rt;
    logic        halt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] prog1 [6] = '{32'h00500093, 32'h00108133, 32'h00108093,
                               32'hfe209ee3, 32'h00908513, 32'h00050f13};
    logic [31:0] pc1   [16] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd8, 32'd12, 32'd8, 32'd12,
                                32'd8, 32'd12, 32'd8, 32'd12, 32'd16, 32'd20, 32'd20, 32'd20};
    logic [31:0] prog2 [8] = '{32'h02a00193, 32'h00302423, 32'h00802203, 32'h004202b3,
                               32'h00700013, 32'h00000333, 32'h006283b3, 32'h00050f13};

    rv32_single_cycle_core dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .r_pc      (r_pc),
        .w_ir      (w_ir),
        .w_r1      (w_r1),
        .w_s2      (w_s2),
        .w_rt      (w_rt),
        .halt      (halt)
    );

    always #5 w_clk = ~w_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic imem_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge w_clk);
        imem_we    = 1'b1;
        imem_addr  = a;
        imem_wdata = d;
        @(negedge w_clk);
        imem_we    = 1'b0;
    endtask

    // Steps the loop program from PC 0, checking PC every cycle and taps at key points
    task automatic run_prog1(input int n_steps);
        for (int i = 0; i < n_steps; i++) begin
            check($sformatf("p1_pc%0d", i), r_pc, pc1[i]);
            if (i == 0) check("p1_halt_low", {31'd0, halt}, 32'd0);
            if (i == 1) begin
                check("p1_add_r1", w_r1, 32'd5);
                check("p1_add_s2", w_s2, 32'd5);
                check("p1_add_rt", w_rt, 32'd10);
            end
            if (i == 2) begin
                check("p1_it1_r1", w_r1, 32'd5);
                check("p1_it1_s2", w_s2, 32'd1);
                check("p1_it1_rt", w_rt, 32'd6);
            end
            if (i == 7) begin
                check("p1_mid_x1", w_r1, 32'd8);
                check("p1_mid_x2", w_s2, 32'd10);
            end
            if (i == 11) check("p1_last_x1", w_r1, 32'd10);
            if (i == 12) check("p1_x10_rt", w_rt, 32'd19);
            if (i >= 13) begin
                check($sformatf("p1_halt%0d", i), {31'd0, halt}, 32'd1);
                check($sformatf("p1_x10_%0d", i), w_r1, 32'd19);
            end
            @(negedge w_clk);
        end
    endtask

    initial begin
        w_rst      = 1'b1;
        imem_we    = 1'b0;
        imem_addr  = 5'd0;
        imem_wdata = 32'd0;
        #1;
        check("reset_pc", r_pc, 32'd0);
        for (int i = 0; i < 6; i++) imem_write(5'(i), prog1[i]);
        w_rst = 1'b0;
        run_prog1(16);

        // Async reset mid-loop, between clock edges
        w_rst = 1'b1;
        @(negedge w_clk);
        w_rst = 1'b0;
        run_prog1(8);
        #2 w_rst = 1'b1;
        #1 check("areset_pc", r_pc, 32'd0);
        imem_write(5'd0, 32'h00208033);
        check("areset_ir", w_ir, 32'h00208033);
        check("areset_x1", w_r1, 32'd0);
        check("areset_x2", w_s2, 32'd0);
        imem_write(5'd0, prog1[0]);
        w_rst = 1'b0;
        run_prog1(16);

        // Store/load and x0 protection
        w_rst = 1'b1;
        for (int i = 0; i < 8; i++) imem_write(5'(i), prog2[i]);
        w_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("p2_pc%0d", i), r_pc, (i < 7) ? 32'(i * 4) : 32'd28);
            if (i == 1) begin
                check("p2_sw_data", w_r1, 32'd0);
                check("p2_sw_addr", w_rt, 32'd8);
            end
            if (i == 2) check("p2_lw_addr", w_rt, 32'd8);
            if (i == 3) begin
                check("p2_x4", w_r1, 32'd42);
                check("p2_x5_rt", w_rt, 32'd84);
            end
            if (i == 5) begin
                check("p2_x0_r1", w_r1, 32'd0);
                check("p2_x0_rt", w_rt, 32'd0);
            end
            if (i == 6) begin
                check("p2_x5", w_r1, 32'd84);
                check("p2_x6", w_s2, 32'd0);
            end
            if (i >= 7) check($sformatf("p2_halt%0d", i), {31'd0, halt}, 32'd1);
            @(negedge w_clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
